// File: rtl/usb_cdc_pkg.sv
// Definitions shared by the USB CDC IN and OUT data paths.
// Byte width, the handshake byte type and the line-sampling constant.
package usb_cdc_pkg;

    localparam int BYTE_W      = 8;
    localparam int BIT_SAMPLES = 4;

    typedef logic [BYTE_W-1:0] cdc_byte_t;

    // A byte together with its valid qualifier, as carried on the core handshakes.
    typedef struct packed {
        cdc_byte_t data;
        logic      valid;
    } cdc_hs_byte_t;

    // Pointer width for a circular buffer whose MSB separates full from empty.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb_cdc_fifo_mem.sv
// DEPTH x BYTE_W register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module usb_cdc_fifo_mem
    import usb_cdc_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  cdc_byte_t     wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output cdc_byte_t     rd_data_o
);

    cdc_byte_t mem_reg [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_reg[wr_addr_i] <= wr_data_i;
        end
    end

    // First-word-fall-through: the head byte is visible without a read strobe.
    assign rd_data_o = mem_reg[rd_addr_i];

endmodule

// File: rtl/usb_cdc_in_fifo.sv
// Byte FIFO feeding the USB CDC core's IN path, gated on the host configuration state.
// Unconfigured behaviour is either drop-and-flush or hold-and-backpressure.
module usb_cdc_in_fifo
    import usb_cdc_pkg::*;
#(
    parameter int DEPTH             = 16,
    parameter bit DROP_UNCONFIGURED = 1'b1,
    localparam int AW               = $clog2(DEPTH),
    localparam int PW               = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          configured_i,
    input  cdc_byte_t     wr_data_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output cdc_byte_t     in_data_o,
    output logic          in_valid_o,
    input  logic          in_ready_i,
    output logic [PW-1:0] level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o
);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          overflow_reg, overflow_next;

    logic drop_now;
    logic push;
    logic pop;
    logic mem_wr_en;

    assign drop_now = DROP_UNCONFIGURED && !configured_i;

    assign level_o    = wr_ptr_reg - rd_ptr_reg;
    assign empty_o    = (level_o == '0);
    assign full_o     = (level_o == PW'(DEPTH));
    assign overflow_o = overflow_reg;

    // wr_ready depends only on registers and configured_i, never on in_ready_i.
    assign wr_ready_o = drop_now || !full_o;
    assign in_valid_o = configured_i && !empty_o;

    assign push = wr_valid_i && wr_ready_o && !drop_now;
    assign pop  = in_valid_o && in_ready_i;

    assign mem_wr_en = push && !clr_i && !rst_i;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        overflow_next = overflow_reg;
        if (clr_i) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            overflow_next = 1'b0;
        end else begin
            if (wr_valid_i && !wr_ready_o) begin
                overflow_next = 1'b1;
            end
            if (drop_now) begin
                // Collapse to empty while the host is away; nothing is written.
                rd_ptr_next = wr_ptr_reg;
            end else begin
                if (push) begin
                    wr_ptr_next = wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_next = rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            overflow_reg <= overflow_next;
        end
    end

    usb_cdc_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i    (clk_i),
        .wr_en_i  (mem_wr_en),
        .wr_addr_i(wr_ptr_reg[AW-1:0]),
        .wr_data_i(wr_data_i),
        .rd_addr_i(rd_ptr_reg[AW-1:0]),
        .rd_data_o(in_data_o)
    );

endmodule
